// File: rtl/spi_slave_regbank_pkg.sv
// Shared constants, command layout and address helpers for the SPI slave register bank.
package spi_slave_regbank_pkg;

  localparam int unsigned CMD_WIDTH = 8;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned CNT_W     = 6;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CMD     = 2'd1;
  localparam logic [1:0] ST_DATA    = 2'd2;
  localparam logic [1:0] ST_WAIT_SS = 2'd3;

  typedef struct packed {
    logic              rnw;
    logic [ADDR_W-1:0] addr;
  } cmd_t;

  // Out-of-range addresses are first folded into range, then incremented with wrap.
  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] addr,
                                                 input int unsigned num_regs);
    int unsigned base;
    base = 32'(addr) % num_regs;
    return (base + 1 >= num_regs) ? '0 : ADDR_W'(base + 1);
  endfunction

endpackage

// File: rtl/spi_slave_regbank_if.sv
// SPI pin bundle between an SPI master and the register bank.
interface spi_slave_regbank_if;
  logic sck;
  logic mosi;
  logic ss_n;
  logic miso;
  logic miso_oe;

  modport master (output sck, output mosi, output ss_n, input miso, input miso_oe);
  modport slave  (input sck, input mosi, input ss_n, output miso, output miso_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous input with rise/fall detection on the synced level.
module spi_sync_edge #(
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_LEVEL;
      sync_q <= RESET_LEVEL;
      prev_q <= RESET_LEVEL;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_regbank.sv
// SPI slave register bank, oversampled in the fabric clock domain; supports all four SPI modes,
// burst writes with address wrap and MISO read-back.
module spi_slave_regbank
  import spi_slave_regbank_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           NUM_REGS   = 4,
  parameter bit                    CPOL       = 1'b0,
  parameter bit                    CPHA       = 1'b0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  spi_slave_regbank_if.slave             spi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic                           wr_stb,
  output logic [ADDR_W-1:0]              wr_addr,
  output logic                           frame_err
);

  logic sck_level, sck_rise, sck_fall;
  logic mosi, mosi_rise, mosi_fall;
  logic ss_n, ss_rise, ss_fall;

  spi_sync_edge #(.RESET_LEVEL(CPOL)) u_sync_sck (
    .clk(clk), .reset(reset), .din(spi.sck), .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );
  spi_sync_edge #(.RESET_LEVEL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(spi.mosi), .level(mosi), .rise(mosi_rise), .fall(mosi_fall)
  );
  // Select resets to "asserted" so a frame in flight at reset stays ignored until SS_N rises.
  spi_sync_edge #(.RESET_LEVEL(1'b0)) u_sync_ss (
    .clk(clk), .reset(reset), .din(spi.ss_n), .level(ss_n), .rise(ss_rise), .fall(ss_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sck_level, mosi_rise, mosi_fall, ss_rise, ss_fall};

  logic lead_edge, trail_edge, sample_edge, drive_edge;
  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign drive_edge  = CPHA ? lead_edge : trail_edge;

  logic [1:0]                       state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]            rx_q, rx_d, tx_q, tx_d, rx_word;
  logic                             rnw_q, rnw_d;
  logic [ADDR_W-1:0]                addr_q, addr_d, addr_next;
  logic [NUM_REGS*DATA_WIDTH-1:0]   regs_q, regs_d;
  logic                             wr_stb_q, wr_stb_d, frame_err_q, frame_err_d;
  logic                             miso_oe_q, miso_oe_d, in_range;
  logic [ADDR_W-1:0]                wr_addr_q, wr_addr_d;
  cmd_t                             cmd;

  function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [NUM_REGS*DATA_WIDTH-1:0] regs,
                                                     input logic [ADDR_W-1:0] addr);
    logic [DATA_WIDTH-1:0] val;
    val = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) val = regs[i*DATA_WIDTH +: DATA_WIDTH];
    end
    return val;
  endfunction

  assign rx_word   = {rx_q[DATA_WIDTH-2:0], mosi};
  assign cmd       = cmd_t'(rx_word[CMD_WIDTH-1:0]);
  assign in_range  = 32'(addr_q) < NUM_REGS;
  assign addr_next = wrap_inc(addr_q, NUM_REGS);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rnw_d       = rnw_q;
    addr_d      = addr_q;
    regs_d      = regs_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;
    miso_oe_d   = miso_oe_q;
    if (ss_n) begin
      state_d     = ST_IDLE;
      miso_oe_d   = 1'b0;
      cnt_d       = '0;
      frame_err_d = (state_q == ST_CMD || state_q == ST_DATA) && (cnt_q != '0);
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d   = ST_CMD;
          miso_oe_d = 1'b1;
          cnt_d     = '0;
        end
        ST_CMD: begin
          if (sample_edge) begin
            rx_d = rx_word;
            if (cnt_q == CNT_W'(CMD_WIDTH - 1)) begin
              cnt_d   = '0;
              state_d = ST_DATA;
              rnw_d   = cmd.rnw;
              addr_d  = cmd.addr;
              if (cmd.rnw) tx_d = read_reg(regs_q, cmd.addr);
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (sample_edge) begin
            rx_d = rx_word;
            if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
              cnt_d  = '0;
              addr_d = addr_next;
              if (!rnw_q && in_range) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                  if (addr_q == ADDR_W'(i)) regs_d[i*DATA_WIDTH +: DATA_WIDTH] = rx_word;
                end
                wr_stb_d  = 1'b1;
                wr_addr_d = addr_q;
              end
              if (rnw_q) tx_d = read_reg(regs_q, addr_next);
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          // A drive edge at bit 0 would skip the freshly loaded MSB, so it is held instead.
          end else if (drive_edge && cnt_q != '0) begin
            tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
        ST_WAIT_SS: ;
        default: state_d = ST_WAIT_SS;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_WAIT_SS;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rnw_q       <= 1'b0;
      addr_q      <= '0;
      regs_q      <= {NUM_REGS{RESET_VAL}};
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      regs_q      <= regs_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
      miso_oe_q   <= miso_oe_d;
    end
  end

  assign spi.miso    = (state_q == ST_DATA && rnw_q) ? tx_q[DATA_WIDTH-1] : 1'b0;
  assign spi.miso_oe = miso_oe_q;
  assign regs_out    = regs_q;
  assign wr_stb      = wr_stb_q;
  assign wr_addr     = wr_addr_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_regbank.sv
// Directed bench: four bank instances, one per SPI mode, driven by a bit-banged SPI master.
module tb_spi_slave_regbank;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mosi = 1'b0;
  logic       sck [4];
  logic       ss_n [4];
  wire        miso [4];
  wire        miso_oe [4];
  wire [31:0] regs [4];
  wire        wr_stb [4];
  wire [6:0]  wr_addr [4];
  wire        frame_err [4];

  int errors = 0;
  int checks = 0;
  logic [6:0] stb_q [$];
  int ferr_cnt = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_regbank_if bus ();
    assign bus.sck  = sck[g];
    assign bus.mosi = mosi;
    assign bus.ss_n = ss_n[g];
    assign miso[g]    = bus.miso;
    assign miso_oe[g] = bus.miso_oe;
    spi_slave_regbank #(
      .DATA_WIDTH(8), .NUM_REGS(4), .CPOL(g >= 2), .CPHA((g % 2) == 1),
      .RESET_VAL((g == 0) ? 8'h3C : 8'h00)
    ) u_dut (
      .clk(clk), .reset(reset), .spi(bus), .regs_out(regs[g]), .wr_stb(wr_stb[g]),
      .wr_addr(wr_addr[g]), .frame_err(frame_err[g])
    );
  end

  always @(negedge clk) begin
    if (wr_stb[0] === 1'b1) stb_q.push_back(wr_addr[0]);
    if (frame_err[0] === 1'b1) ferr_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input int m, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    logic cpol, cpha;
    cpol = (m >= 2);
    cpha = (m % 2) == 1;
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = tx[7-i];
        tick(HALF);
        rx[7-i] = miso[m];
        sck[m] = ~cpol;
        tick(HALF);
        sck[m] = cpol;
      end else begin
        sck[m] = ~cpol;
        mosi = tx[7-i];
        tick(HALF);
        rx[7-i] = miso[m];
        sck[m] = cpol;
        tick(HALF);
      end
    end
  endtask

  task automatic frame_start(input int m);
    ss_n[m] = 1'b0;
    tick(2 * HALF);
  endtask

  task automatic frame_end(input int m);
    tick(HALF);
    ss_n[m] = 1'b1;
    tick(3 * HALF);
  endtask

  task automatic write_frame(input int m, input logic [7:0] cmd, input logic [7:0] data);
    logic [7:0] rx;
    frame_start(m);
    xfer(m, cmd, 8, rx);
    xfer(m, data, 8, rx);
    frame_end(m);
  endtask

  task automatic test_reset();
    checks++;
    if (regs[0] !== 32'h3C3C3C3C) begin
      errors++; $display("FAIL reset_regs: got %h want %h", regs[0], 32'h3C3C3C3C);
    end
    checks++;
    if (regs[1] !== 32'h0) begin
      errors++; $display("FAIL reset_regs_m1: got %h want %h", regs[1], 32'h0);
    end
    checks++;
    if ({wr_stb[0], wr_addr[0], frame_err[0]} !== 9'b0) begin
      errors++; $display("FAIL reset_strobes: got stb=%b addr=%h ferr=%b want 0/00/0",
                         wr_stb[0], wr_addr[0], frame_err[0]);
    end
    checks++;
    if ({miso[0], miso_oe[0]} !== 2'b00) begin
      errors++; $display("FAIL reset_miso: got miso=%b oe=%b want 0/0", miso[0], miso_oe[0]);
    end
  endtask

  task automatic test_single_write();
    int n0 = stb_q.size();
    int f0 = ferr_cnt;
    write_frame(0, 8'h02, 8'hA5);
    checks++;
    if (regs[0] !== 32'h3CA53C3C) begin
      errors++; $display("FAIL single_write_regs: got %h want %h", regs[0], 32'h3CA53C3C);
    end
    checks++;
    if (stb_q.size() - n0 !== 1 || stb_q[n0] !== 7'd2) begin
      errors++; $display("FAIL single_write_stb: got %0d pulses want 1 at addr 2", stb_q.size()-n0);
    end
    checks++;
    if (ferr_cnt !== f0) begin
      errors++; $display("FAIL single_write_ferr: got %0d want 0", ferr_cnt - f0);
    end
  endtask

  task automatic test_burst_wrap();
    logic [7:0] rx;
    int n0 = stb_q.size();
    frame_start(0);
    xfer(0, 8'h03, 8, rx);
    xfer(0, 8'h11, 8, rx);
    xfer(0, 8'h22, 8, rx);
    xfer(0, 8'h33, 8, rx);
    frame_end(0);
    checks++;
    if (regs[0] !== 32'h11A53322) begin
      errors++; $display("FAIL burst_regs: got %h want %h", regs[0], 32'h11A53322);
    end
    checks++;
    if (stb_q.size() - n0 !== 3) begin
      errors++; $display("FAIL burst_stb_count: got %0d want 3", stb_q.size() - n0);
    end else begin
      checks++;
      if ({stb_q[n0], stb_q[n0+1], stb_q[n0+2]} !== {7'd3, 7'd0, 7'd1}) begin
        errors++; $display("FAIL burst_stb_addr: got %0d,%0d,%0d want 3,0,1",
                           stb_q[n0], stb_q[n0+1], stb_q[n0+2]);
      end
    end
  endtask

  task automatic test_readback();
    logic [7:0] rx_cmd, rx_dat;
    for (int m = 0; m < 4; m++) begin
      write_frame(m, 8'h01, 8'h5C);
      frame_start(m);
      xfer(m, 8'h81, 8, rx_cmd);
      checks++;
      if (miso_oe[m] !== 1'b1) begin
        errors++; $display("FAIL read_oe_active m%0d: got %b want 1", m, miso_oe[m]);
      end
      xfer(m, 8'h00, 8, rx_dat);
      frame_end(m);
      checks++;
      if (rx_cmd !== 8'h00 || rx_dat !== 8'h5C) begin
        errors++; $display("FAIL read_data m%0d: got cmd=%h data=%h want 00/5c", m, rx_cmd, rx_dat);
      end
      checks++;
      if ({miso_oe[m], miso[m]} !== 2'b00 || regs[m][15:8] !== 8'h5C) begin
        errors++; $display("FAIL read_end m%0d: got oe=%b miso=%b reg1=%h want 0/0/5c",
                           m, miso_oe[m], miso[m], regs[m][15:8]);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    int n0 = stb_q.size();
    int f0 = ferr_cnt;
    frame_start(0);
    xfer(0, 8'h00, 8, rx);
    xfer(0, 8'hFF, 5, rx);
    frame_end(0);
    checks++;
    if (regs[0][7:0] !== 8'h22 || stb_q.size() !== n0) begin
      errors++; $display("FAIL abort_nowrite: got reg0=%h stb=%0d want 22/0",
                         regs[0][7:0], stb_q.size() - n0);
    end
    checks++;
    if (ferr_cnt - f0 !== 1) begin
      errors++; $display("FAIL abort_ferr: got %0d want 1", ferr_cnt - f0);
    end
    write_frame(0, 8'h00, 8'h4B);
    checks++;
    if (regs[0] !== 32'h11A55C4B || ferr_cnt - f0 !== 1 || stb_q.size() - n0 !== 1) begin
      errors++; $display("FAIL abort_recover: got regs=%h ferr=%0d stb=%0d want 11a55c4b/1/1",
                         regs[0], ferr_cnt - f0, stb_q.size() - n0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] rx;
    int n0, f0;
    frame_start(0);
    xfer(0, 8'h01, 8, rx);
    xfer(0, 8'hFF, 3, rx);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    n0 = stb_q.size();
    f0 = ferr_cnt;
    xfer(0, 8'hFF, 5, rx);
    xfer(0, 8'h77, 8, rx);
    frame_end(0);
    checks++;
    if (regs[0] !== 32'h3C3C3C3C || stb_q.size() !== n0 || ferr_cnt !== f0) begin
      errors++; $display("FAIL reset_mid_ignored: got regs=%h stb=%0d ferr=%0d want 3c3c3c3c/0/0",
                         regs[0], stb_q.size() - n0, ferr_cnt - f0);
    end
    write_frame(0, 8'h01, 8'hFF);
    checks++;
    if (regs[0] !== 32'h3C3CFF3C) begin
      errors++; $display("FAIL reset_mid_next: got %h want %h", regs[0], 32'h3C3CFF3C);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] rx_cmd, rx_dat;
    int n0 = stb_q.size();
    write_frame(0, 8'h05, 8'h77);
    checks++;
    if (regs[0] !== 32'h3C3CFF3C || stb_q.size() !== n0) begin
      errors++; $display("FAIL oor_write: got regs=%h stb=%0d want 3c3cff3c/0",
                         regs[0], stb_q.size() - n0);
    end
    frame_start(0);
    xfer(0, 8'h85, 8, rx_cmd);
    xfer(0, 8'hFF, 8, rx_dat);
    frame_end(0);
    checks++;
    if (rx_dat !== 8'h00 || regs[0] !== 32'h3C3CFF3C) begin
      errors++; $display("FAIL oor_read: got data=%h regs=%h want 00/3c3cff3c", rx_dat, regs[0]);
    end
  endtask

  initial begin
    sck[0] = 1'b0; sck[1] = 1'b0; sck[2] = 1'b1; sck[3] = 1'b1;
    for (int i = 0; i < 4; i++) ss_n[i] = 1'b1;
    tick(4);
    reset = 1'b0;
    tick(8);
    test_reset();
    test_single_write();
    test_burst_wrap();
    test_readback();
    test_abort();
    test_reset_mid_frame();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
